// File: rtl/video_sync_encoder_if.sv
// Counter/RGB input bundle and display-ready output bundle of video_sync_encoder.
// master = upstream/driver side, slave = the encoder itself.
`timescale 1ns/1ps
interface video_sync_encoder_if;
    logic [9:0] HCTRs_i;
    logic [8:0] VCTRs_i;
    logic [7:0] R_i;
    logic [7:0] G_i;
    logic [7:0] B_i;
    logic [7:0] R_o;
    logic [7:0] G_o;
    logic [7:0] B_o;
    logic       HS_o;
    logic       VS_o;
    logic       DE_o;
    logic       FS_o;
    logic       FLD_o;
    logic       ERR_o;

    modport master (
        output HCTRs_i, VCTRs_i, R_i, G_i, B_i,
        input  R_o, G_o, B_o, HS_o, VS_o, DE_o, FS_o, FLD_o, ERR_o
    );

    modport slave (
        input  HCTRs_i, VCTRs_i, R_i, G_i, B_i,
        output R_o, G_o, B_o, HS_o, VS_o, DE_o, FS_o, FLD_o, ERR_o
    );
endinterface

// File: rtl/video_sync_encoder.sv
// Sync/DE/blanking encoder behind the pattern generator; counters to outputs 2 enabled cycles, RGB 1.
// No backpressure: CK_EE_i low freezes every register, RST_i overrides CK_EE_i.
`timescale 1ns/1ps
module video_sync_encoder #(
    parameter int unsigned H_ACT        = 720,
    parameter int unsigned H_SYNC_START = 736,
    parameter int unsigned H_SYNC_LEN   = 62,
    parameter int unsigned V_ACT        = 240,
    parameter int unsigned V_SYNC_START = 244,
    parameter int unsigned V_SYNC_LEN   = 3,
    parameter bit          SYNC_POL     = 1'b0
) (
    input  logic                 CK_i,
    input  logic                 RST_i,
    input  logic                 CK_EE_i,
    video_sync_encoder_if.slave  vid
);
    localparam logic [10:0] H_ACT_W = 11'(H_ACT);
    localparam logic [10:0] H_SS_W  = 11'(H_SYNC_START);
    localparam logic [10:0] H_SE_W  = 11'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [9:0]  V_ACT_W = 10'(V_ACT);
    localparam logic [9:0]  V_SS_W  = 10'(V_SYNC_START);
    localparam logic [9:0]  V_SE_W  = 10'(V_SYNC_START + V_SYNC_LEN);
    localparam logic        SYNC_IDLE = ~SYNC_POL;

    // Stage 1: counter copy plus monitor/field events aligned with it
    logic [9:0] r_h;
    logic [8:0] r_v;
    logic       r_first;
    logic       r_seq_err;
    logic       r_fld_tog;

    // Stage 2: output registers
    logic       r_de;
    logic       r_hs;
    logic       r_vs;
    logic       r_fs;
    logic       r_fld;
    logic       r_err;
    logic [7:0] r_r;
    logic [7:0] r_g;
    logic [7:0] r_b;

    logic [10:0] w_h;
    logic [9:0]  w_v;
    logic [10:0] w_h_in;
    logic [9:0]  w_v_in;
    logic        w_de;
    logic        w_hs;
    logic        w_vs;
    logic        w_fs;
    logic        w_h_ok;
    logic        w_v_ok;
    logic        w_seq_bad;
    logic        w_fld_tog;

    assign w_h    = {1'b0, r_h};
    assign w_v    = {1'b0, r_v};
    assign w_h_in = {1'b0, vid.HCTRs_i};
    assign w_v_in = {1'b0, vid.VCTRs_i};

    // r_first marks stage 1 as still holding reset contents, so decode is forced idle
    assign w_de = ~r_first & (w_h < H_ACT_W) & (w_v < V_ACT_W);
    assign w_hs = ~r_first & (w_h >= H_SS_W) & (w_h < H_SE_W);
    assign w_vs = ~r_first & (w_v >= V_SS_W) & (w_v < V_SE_W);
    assign w_fs = ~r_first & (r_h == 10'd0) & (r_v == 9'd0);

    // The incoming count is checked against the current stage-1 count (its predecessor)
    // and the verdict is registered alongside it, keeping ERR_o aligned with the other outputs.
    assign w_h_ok = (w_h_in == w_h + 11'd1) || (vid.HCTRs_i == 10'd0);
    assign w_v_ok = (w_v_in == w_v) ||
                    ((vid.HCTRs_i == 10'd0) && ((w_v_in == w_v + 10'd1) || (vid.VCTRs_i == 9'd0)));
    assign w_seq_bad = ~r_first & ~(w_h_ok & w_v_ok);
    assign w_fld_tog = ~r_first & (vid.VCTRs_i == 9'd0) & (r_v != 9'd0);

    always_ff @(posedge CK_i) begin
        if (RST_i) begin
            r_h       <= '0;
            r_v       <= '0;
            r_first   <= 1'b1;
            r_seq_err <= 1'b0;
            r_fld_tog <= 1'b0;
        end else if (CK_EE_i) begin
            r_h       <= vid.HCTRs_i;
            r_v       <= vid.VCTRs_i;
            r_first   <= 1'b0;
            r_seq_err <= w_seq_bad;
            r_fld_tog <= w_fld_tog;
        end
    end

    always_ff @(posedge CK_i) begin
        if (RST_i) begin
            r_de  <= 1'b0;
            r_hs  <= SYNC_IDLE;
            r_vs  <= SYNC_IDLE;
            r_fs  <= 1'b0;
            r_fld <= 1'b0;
            r_err <= 1'b0;
            r_r   <= '0;
            r_g   <= '0;
            r_b   <= '0;
        end else if (CK_EE_i) begin
            r_de  <= w_de;
            r_hs  <= w_hs ^ SYNC_IDLE;
            r_vs  <= w_vs ^ SYNC_IDLE;
            r_fs  <= w_fs;
            r_fld <= r_fld ^ r_fld_tog;
            r_err <= r_err | r_seq_err;
            // RGB arrives one cycle behind the counters, so it lines up with the stage-1 decode
            r_r   <= w_de ? vid.R_i : 8'h00;
            r_g   <= w_de ? vid.G_i : 8'h00;
            r_b   <= w_de ? vid.B_i : 8'h00;
        end
    end

    assign vid.R_o   = r_r;
    assign vid.G_o   = r_g;
    assign vid.B_o   = r_b;
    assign vid.HS_o  = r_hs;
    assign vid.VS_o  = r_vs;
    assign vid.DE_o  = r_de;
    assign vid.FS_o  = r_fs;
    assign vid.FLD_o = r_fld;
    assign vid.ERR_o = r_err;
endmodule

// File: tb/tb_video_sync_encoder.sv
// Directed bench for video_sync_encoder: line/field structure, enable stalls, sequence monitor, reset, polarity.
`timescale 1ns/1ps
module tb_video_sync_encoder;
    logic clk = 1'b0;
    logic rst;
    logic ck_ee;

    always #5 clk = ~clk;

    video_sync_encoder_if vif ();
    video_sync_encoder_if vifp ();

    assign vifp.HCTRs_i = vif.HCTRs_i;
    assign vifp.VCTRs_i = vif.VCTRs_i;
    assign vifp.R_i     = vif.R_i;
    assign vifp.G_i     = vif.G_i;
    assign vifp.B_i     = vif.B_i;

    video_sync_encoder dut (
        .CK_i    (clk),
        .RST_i   (rst),
        .CK_EE_i (ck_ee),
        .vid     (vif)
    );

    video_sync_encoder #(.SYNC_POL(1'b1)) dut_p (
        .CK_i    (clk),
        .RST_i   (rst),
        .CK_EE_i (ck_ee),
        .vid     (vifp)
    );

    int n_chk = 0;
    int n_err = 0;
    int ph = 0, pv = 0, napp = 0;
    int de_cnt, de_first, de_last, de_vmax;
    int hs_cnt, hs_first, hs_last;
    int vs_cnt, vs_first_v, vs_last_v;
    int fs_cnt, fs_bad, rgb_err, hold_err;
    int pol_err = 0;
    logic fld_fs[$];
    logic [23:0] exp_px;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] pix(input int h, input int v);
        logic [9:0] hh;
        logic [8:0] vv;
        hh = h[9:0];
        vv = v[8:0];
        return {hh[7:0] + 8'h11, {hh[9:8], vv[5:0]}, vv[7:0] ^ 8'hA5};
    endfunction

    task automatic clear_stats();
        de_cnt = 0; de_first = -1; de_last = -1; de_vmax = -1;
        hs_cnt = 0; hs_first = -1; hs_last = -1;
        vs_cnt = 0; vs_first_v = -1; vs_last_v = -1;
        fs_cnt = 0; fs_bad = 0; rgb_err = 0; hold_err = 0;
        fld_fs.delete();
    endtask

    task automatic sample(input int oh, input int ov);
        logic [23:0] rgb;
        rgb = {vif.R_o, vif.G_o, vif.B_o};
        if (vif.DE_o) begin
            de_cnt++;
            if (de_first < 0) de_first = oh;
            de_last = oh;
            if (ov > de_vmax) de_vmax = ov;
            if (rgb !== pix(oh, ov)) rgb_err++;
        end else if (rgb !== 24'd0) begin
            rgb_err++;
        end
        if (vif.HS_o === 1'b0) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = oh;
            hs_last = oh;
        end
        if (vif.VS_o === 1'b0) begin
            vs_cnt++;
            if (vs_first_v < 0) vs_first_v = ov;
            vs_last_v = ov;
        end
        if (vif.FS_o) begin
            fs_cnt++;
            fld_fs.push_back(vif.FLD_o);
            if (oh != 0 || ov != 0) fs_bad++;
        end
        if (vifp.HS_o !== ~vif.HS_o || vifp.VS_o !== ~vif.VS_o || vifp.DE_o !== vif.DE_o ||
            vifp.FS_o !== vif.FS_o || vifp.R_o !== vif.R_o)
            pol_err++;
    endtask

    // One enabled cycle: drive counter (h,v) with the pixel of the previous count
    task automatic apply(input int h, input int v);
        @(negedge clk);
        rst   = 1'b0;
        ck_ee = 1'b1;
        vif.HCTRs_i = h[9:0];
        vif.VCTRs_i = v[8:0];
        {vif.R_i, vif.G_i, vif.B_i} = pix(ph, pv);
        @(posedge clk);
        #1;
        napp++;
        if (napp >= 2) sample(ph, pv);
        ph = h;
        pv = v;
    endtask

    // One disabled cycle with junk on the inputs; nothing may move
    task automatic hold();
        logic [30:0] snap;
        snap = {vif.R_o, vif.G_o, vif.B_o, vif.HS_o, vif.VS_o, vif.DE_o, vif.FS_o, vif.FLD_o, vif.ERR_o};
        @(negedge clk);
        ck_ee = 1'b0;
        vif.HCTRs_i = 10'd1000;
        vif.VCTRs_i = 9'd500;
        {vif.R_i, vif.G_i, vif.B_i} = 24'hFFFFFF;
        @(posedge clk);
        #1;
        if ({vif.R_o, vif.G_o, vif.B_o, vif.HS_o, vif.VS_o, vif.DE_o, vif.FS_o, vif.FLD_o, vif.ERR_o} !== snap)
            hold_err++;
    endtask

    task automatic do_reset(input logic en);
        @(negedge clk);
        rst   = 1'b1;
        ck_ee = en;
        @(posedge clk);
        #1;
        napp = 0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_rgb"}, {vif.R_o, vif.G_o, vif.B_o}, 24'd0);
        chk({tag, "_de"},  vif.DE_o,  1'b0);
        chk({tag, "_fs"},  vif.FS_o,  1'b0);
        chk({tag, "_fld"}, vif.FLD_o, 1'b0);
        chk({tag, "_err"}, vif.ERR_o, 1'b0);
        chk({tag, "_hs"},  vif.HS_o,  1'b1);
        chk({tag, "_vs"},  vif.VS_o,  1'b1);
        chk({tag, "_hs_pol1"}, vifp.HS_o, 1'b0);
        chk({tag, "_vs_pol1"}, vifp.VS_o, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        ck_ee = 1'b1;
        vif.HCTRs_i = '0;
        vif.VCTRs_i = '0;
        {vif.R_i, vif.G_i, vif.B_i} = 24'd0;
        repeat (3) do_reset(1'b1);
        chk_reset_state("rst0");

        // Full line at V=0 straight out of reset
        clear_stats();
        apply(0, 0);
        chk("de_after_1st", vif.DE_o, 1'b0);
        for (int h = 1; h < 910; h++) begin
            apply(h, 0);
            if (h == 1) begin
                exp_px = pix(0, 0);
                chk("de_rise", vif.DE_o, 1'b1);
                chk("fs_h0", vif.FS_o, 1'b1);
                chk("r_at_h0", vif.R_o, exp_px[23:16]);
            end
        end
        apply(0, 1);
        chk("l0_de_cnt", de_cnt, 720);
        chk("l0_de_first", de_first, 0);
        chk("l0_de_last", de_last, 719);
        chk("l0_hs_cnt", hs_cnt, 62);
        chk("l0_hs_first", hs_first, 736);
        chk("l0_hs_last", hs_last, 797);
        chk("l0_vs_cnt", vs_cnt, 0);
        chk("l0_fs_cnt", fs_cnt, 1);
        chk("l0_rgb", rgb_err, 0);
        chk("l0_fld", vif.FLD_o, 1'b0);

        // Rest of the field and one more, using 8-pixel lines
        clear_stats();
        for (int f = 0; f < 2; f++)
            for (int v = (f == 0) ? 1 : 0; v < 262; v++)
                for (int h = 0; h < 8; h++)
                    apply(h, v);
        apply(0, 0);
        apply(1, 0);
        chk("fld_fs_cnt", fs_cnt, 2);
        chk("fld_fs_pos", fs_bad, 0);
        if (fld_fs.size() == 2) begin
            chk("fld_at_fs1", fld_fs[0], 1'b1);
            chk("fld_at_fs2", fld_fs[1], 1'b0);
        end else begin
            chk("fld_fs_samples", fld_fs.size(), 2);
        end
        chk("fld_vs_cnt", vs_cnt, 48);
        chk("fld_vs_first", vs_first_v, 244);
        chk("fld_vs_last", vs_last_v, 246);
        chk("fld_de_vmax", de_vmax, 239);
        chk("fld_hs_cnt", hs_cnt, 0);
        chk("fld_rgb", rgb_err, 0);
        chk("fld_err", vif.ERR_o, 1'b0);

        // Full line at V=1 with the enable toggling every cycle
        apply(0, 1);
        hold();
        clear_stats();
        for (int h = 1; h < 910; h++) begin
            apply(h, 1);
            hold();
        end
        apply(0, 2);
        hold();
        chk("ce_de_cnt", de_cnt, 720);
        chk("ce_de_first", de_first, 0);
        chk("ce_de_last", de_last, 719);
        chk("ce_hs_cnt", hs_cnt, 62);
        chk("ce_hs_first", hs_first, 736);
        chk("ce_hs_last", hs_last, 797);
        chk("ce_hold", hold_err, 0);
        chk("ce_rgb", rgb_err, 0);
        chk("ce_err", vif.ERR_o, 1'b0);

        // Upstream V reset mid-field is legal and starts a new field
        for (int h = 1; h <= 50; h++) apply(h, 2);
        apply(0, 0);
        chk("vrst_fs_pre", vif.FS_o, 1'b0);
        apply(1, 0);
        chk("vrst_fs", vif.FS_o, 1'b1);
        chk("vrst_fld", vif.FLD_o, 1'b1);
        chk("vrst_err", vif.ERR_o, 1'b0);

        // H jump 100 -> 300
        for (int h = 2; h <= 100; h++) apply(h, 0);
        apply(300, 0);
        chk("hjump_err_1", vif.ERR_o, 1'b0);
        apply(301, 0);
        chk("hjump_err_2", vif.ERR_o, 1'b1);
        hold();
        chk("hjump_err_hold", vif.ERR_o, 1'b1);
        apply(302, 0);
        apply(303, 0);
        chk("hjump_err_sticky", vif.ERR_o, 1'b1);
        chk("pre_rst_de", vif.DE_o, 1'b1);

        // Reset mid-line with the enable low
        do_reset(1'b0);
        chk_reset_state("rst1");

        // Arbitrary first count after reset is not an error; V step off H=0 is
        apply(500, 7);
        chk("rs_de_1st", vif.DE_o, 1'b0);
        apply(501, 7);
        exp_px = pix(500, 7);
        chk("rs_de", vif.DE_o, 1'b1);
        chk("rs_r", vif.R_o, exp_px[23:16]);
        chk("rs_err_a", vif.ERR_o, 1'b0);
        apply(502, 7);
        chk("rs_err_b", vif.ERR_o, 1'b0);
        apply(503, 8);
        chk("vstep_err_1", vif.ERR_o, 1'b0);
        apply(504, 8);
        chk("vstep_err_2", vif.ERR_o, 1'b1);

        chk("pol_inverse", pol_err, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
